sobel_ctrl: RTL

SOBEL_CTRL -- requirements
Module: sobel_ctrl

---
 rtl/sobel_ctrl_if.sv | 28 ++
 rtl/sobel_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sobel_ctrl_if.sv
// Signal bundle between the Sobel window controller and its host, image memory,
// datapath and result memory. The controller uses the slave side.
interface sobel_ctrl_if;
  logic        ready;
  logic        busy;
  logic [16:0] iaddr;
  logic [7:0]  idata;
  logic [71:0] win_data;
  logic        dp_start;
  logic        dp_done;
  logic [7:0]  res_x;
  logic [7:0]  res_y;
  logic [7:0]  res_c;
  logic        cwr;
  logic [1:0]  csel;
  logic [15:0] caddr_wr;
  logic [7:0]  cdata_wr;

  modport slave (
    input  ready, idata, dp_done, res_x, res_y, res_c,
    output busy, iaddr, win_data, dp_start, cwr, csel, caddr_wr, cdata_wr
  );

  modport master (
    output ready, idata, dp_done, res_x, res_y, res_c,
    input  busy, iaddr, win_data, dp_start, cwr, csel, caddr_wr, cdata_wr
  );
endinterface

// File: rtl/sobel_ctrl.sv
// Frame controller for a 3x3 Sobel filter: walks the output image, fetches a
// sliding window from the padded input, hands it to the datapath and writes X/Y/C.
module sobel_ctrl #(
  parameter int IMG_W = 256,
  parameter int PAD_W = 258
) (
  input  logic         clk,
  input  logic         reset,
  sobel_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT, S_WR_X, S_WR_Y, S_WR_C, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     orow_q, orow_d;
  logic [15:0]     ocol_q, ocol_d;
  logic [1:0]      fr_q, fr_d;    // row offset of the current read
  logic [1:0]      fc_q, fc_d;    // column offset of the current read
  logic [8:0][7:0] win_q, win_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      ry_q, ry_d;
  logic [7:0]      rc_q, rc_d;

  logic        last_read;
  logic        last_col;
  logic        last_pix;
  logic [16:0] row_sum;

  assign last_read = (fr_q == 2'd2) && (fc_q == 2'd2);
  assign last_col  = (ocol_q == 16'(IMG_W - 1));
  assign last_pix  = last_col && (orow_q == 16'(IMG_W - 1));
  assign row_sum   = 17'(orow_q) + 17'(fr_q);

  assign bus.win_data = win_q;
  assign bus.caddr_wr = 16'(orow_q * 16'(IMG_W)) + ocol_q;

  // NOTE: every variable driven here gets its default first so no path
  // through the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    fr_d    = fr_q;
    fc_d    = fc_q;
    win_d   = win_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    rc_d    = rc_q;

    bus.busy     = 1'b1;
    bus.dp_start = 1'b0;
    bus.cwr      = 1'b0;
    bus.csel     = 2'b00;
    bus.cdata_wr = 8'h00;
    bus.iaddr    = 17'd0;

    unique case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.ready) begin
          state_d = S_FETCH;
          orow_d  = 16'd0;
          ocol_d  = 16'd0;
          fr_d    = 2'd0;
          fc_d    = 2'd0;
        end
      end
      S_FETCH: begin
        bus.iaddr = 17'(row_sum * 17'(PAD_W)) + 17'(ocol_q) + 17'(fc_q);
        win_d[int'(fr_q) * 3 + int'(fc_q)] = bus.idata;
        if (last_read) begin
          state_d = S_START;
        end else if (fr_q == 2'd2) begin
          fr_d = 2'd0;
          fc_d = fc_q + 2'd1;
        end else begin
          fr_d = fr_q + 2'd1;
        end
      end
      S_START: begin
        bus.dp_start = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (bus.dp_done) begin
          rx_d    = bus.res_x;
          ry_d    = bus.res_y;
          rc_d    = bus.res_c;
          state_d = S_WR_X;
        end
      end
      S_WR_X: begin
        bus.cwr      = 1'b1;
        bus.csel     = 2'b01;
        bus.cdata_wr = rx_q;
        state_d      = S_WR_Y;
      end
      S_WR_Y: begin
        bus.cwr      = 1'b1;
        bus.csel     = 2'b10;
        bus.cdata_wr = ry_q;
        state_d      = S_WR_C;
      end
      S_WR_C: begin
        bus.cwr      = 1'b1;
        bus.csel     = 2'b11;
        bus.cdata_wr = rc_q;
        fr_d         = 2'd0;
        if (last_pix) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          if (last_col) begin
            ocol_d = 16'd0;
            orow_d = orow_q + 16'd1;
            fc_d   = 2'd0;
          end else begin
            // Reuse two columns of the old window; only the right column is fetched.
            ocol_d = ocol_q + 16'd1;
            fc_d   = 2'd2;
            for (int r = 0; r < 3; r++) begin
              win_d[r * 3]     = win_q[r * 3 + 1];
              win_d[r * 3 + 1] = win_q[r * 3 + 2];
            end
          end
        end
      end
      S_DONE: begin
        bus.busy = 1'b0;
        orow_d   = 16'd0;
        ocol_d   = 16'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // the same pre-edge values; the window register is reset too because its
  // contents are visible on win_data during and after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      orow_q  <= 16'd0;
      ocol_q  <= 16'd0;
      fr_q    <= 2'd0;
      fc_q    <= 2'd0;
      win_q   <= '0;
      rx_q    <= 8'h00;
      ry_q    <= 8'h00;
      rc_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      fr_q    <= fr_d;
      fc_q    <= fc_d;
      win_q   <= win_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rc_q    <= rc_d;
    end
  end

endmodule
